shift_reg_seq_ctrl: RTL and testbench
=====================================

Name: shift_reg_seq_ctrl

Overview:
- Command-driven sequencer for a WIDTH-bit shift register with an embedded register and q/q_bar outputs.
- Accepts one command at a time over a valid/ready handshake.
- Executes SISO, PISO, SIPO or PIPO operations in either direction, then pulses done.
- Sits between a host/FSM and serial links so that shift-register traffic is scheduled rather than free-running.

Parameters:
- WIDTH, 4: shift register width in bits (>=2).
- CNT_W, 3: width of cmd_nshift; SISO shift count range 0..2**CNT_W-1.

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  synchronous, active-high reset.
- cmd_valid  input  1  command present.
- cmd_ready  output  1  controller can accept; high only in IDLE.
- cmd_mode  input  2  00 SISO, 01 PISO, 10 SIPO, 11 PIPO.
- cmd_dir  input  1  0 shift right, 1 shift left.
- cmd_pdata  input  WIDTH  parallel load data (PISO/PIPO).
- cmd_nshift  input  CNT_W  shift count (SISO only).
- serial_in  input  1  serial data into register.
- serial_out  output  1  bit leaving register on next shift (combinational from q).
- shift_en  output  1  high in SHIFT state; register shifts at this edge.
- busy  output  1  state != IDLE.
- done  output  1  one-cycle pulse in DONE state.
- q  output  WIDTH  register contents.
- q_bar  output  WIDTH  always ~q.

Behaviour:
- Reset (sync, rst=1 at edge):
  - Values: q=0, q_bar=all ones, state=IDLE, count=0, done=0, shift_en=0, busy=0.
  - Overrides any in-progress command; the command is lost with no done pulse.
  - cmd_ready=1 from the first cycle after reset.
- Handshake:
  - Command accepted on an edge with cmd_valid & cmd_ready.
  - All cmd_* fields latched at acceptance; later changes are ignored.
  - cmd_ready=0 in LOAD/SHIFT/DONE; cmd_valid there is ignored and not queued.
- FSM states: IDLE, LOAD, SHIFT, DONE.
- Transitions from IDLE on accept:
  - PISO, SIPO, PIPO -> LOAD.
  - SISO with nshift>0 -> SHIFT, count=nshift.
  - SISO with nshift=0 -> DONE.
- LOAD (exactly one cycle):
  - PISO: q<=pdata, count=WIDTH -> SHIFT.
  - SIPO: q<=0, count=WIDTH -> SHIFT.
  - PIPO: q<=pdata -> DONE.
- SHIFT: one shift per cycle, count decrements; the edge where count==1 shifts and goes to DONE.
- DONE: done=1 for one cycle -> IDLE. A new command is acceptable in the following cycle.
- Shift right (dir=0): q<={serial_in, q[WIDTH-1:1]}; serial_out=q[0].
- Shift left (dir=1): q<={q[WIDTH-2:0], serial_in}; serial_out=q[WIDTH-1].
- q holds in IDLE, DONE, and LOAD(SISO n/a); the result remains visible until the next command.
- Latency from acceptance edge at cycle 0:
  - PIPO: LOAD c1, DONE c2, ready c3.
  - PISO/SIPO: LOAD c1, SHIFT c2..c(WIDTH+1), DONE c(WIDTH+2).
  - SISO n: SHIFT c1..cn, DONE c(n+1).
- Rollover:
  - cmd_nshift may exceed WIDTH.
  - The register keeps shifting, so data wraps out and serial_in fills it; there is no saturation.
- serial_in is sampled only at SHIFT edges; its value elsewhere is don't-care.

Test Plan:
- Reset: drive rst 2 cycles mid-PISO (during SHIFT) -> next cycle q=0000, q_bar=1111, busy=0, cmd_ready=1, no done pulse.
- PISO right: pdata=4'b1011, dir=0, serial_in=0 -> serial_out during the 4 shift_en cycles = 1,1,0,1; done at c6; final q=0000.
- SIPO right: serial_in=1,0,1,1 on the shift_en cycles -> q after shifts 1000, 0100, 1010, 1101; done at c6 with q=1101, q_bar=0010.
- PIPO then back-to-back SISO left:
  - PIPO pdata=4'b0110 -> q=0110 at c2 with done.
  - SISO n=2, dir=1, serial_in=1 accepted at c3 -> q=1101 then 1011; done 3 cycles after acceptance.
- SISO n=0: accept -> done the next cycle, q unchanged, no shift_en.
- Busy rejection: hold cmd_valid=1 with a different PIPO command throughout a PISO -> it is not accepted until the cycle after done; the first command's output is unaffected.

Source files
------------

// File: rtl/shift_reg_seq_ctrl.sv
// ---------------------------------------------------------------------------
// shift_reg_seq_ctrl
//   Command-driven sequencer wrapped around a WIDTH-bit shift register.
//   A host hands over one command at a time (valid/ready). The command runs
//   one of four operations in either direction, then the block pulses done:
//     SISO : shift cmd_nshift times (0 is a no-op that still pulses done)
//     PISO : load cmd_pdata, then shift WIDTH times out of serial_out
//     SIPO : clear, then shift WIDTH bits in from serial_in
//     PIPO : load cmd_pdata, no shifting
//
// Ports
//   clk, rst      rising-edge clock, synchronous active-high reset
//   cmd_valid     command present            cmd_ready  high only in IDLE
//   cmd_mode      00 SISO 01 PISO 10 SIPO 11 PIPO
//   cmd_dir       0 shift right, 1 shift left
//   cmd_pdata     parallel load value (PISO/PIPO)
//   cmd_nshift    shift count (SISO only)
//   serial_in     bit entering the register on a shift edge
//   serial_out    bit that leaves on the next shift (combinational from q)
//   shift_en      register shifts at the end of this cycle
//   busy          controller is not idle
//   done          one-cycle completion pulse
//   q, q_bar      register contents and its complement
// ---------------------------------------------------------------------------
module shift_reg_seq_ctrl #(
   parameter int WIDTH = 4,
   parameter int CNT_W = 3
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             cmd_valid,
   output logic             cmd_ready,
   input  logic [1:0]       cmd_mode,
   input  logic             cmd_dir,
   input  logic [WIDTH-1:0] cmd_pdata,
   input  logic [CNT_W-1:0] cmd_nshift,
   input  logic             serial_in,
   output logic             serial_out,
   output logic             shift_en,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] q,
   output logic [WIDTH-1:0] q_bar
);

   // The counter has to hold both the SISO shift count and WIDTH.
   localparam int WCNT_W = $clog2(WIDTH + 1);
   localparam int CW     = (CNT_W > WCNT_W) ? CNT_W : WCNT_W;

   localparam logic [1:0] M_SISO = 2'b00;
   localparam logic [1:0] M_PISO = 2'b01;
   localparam logic [1:0] M_SIPO = 2'b10;
   localparam logic [1:0] M_PIPO = 2'b11;

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_LOAD  = 2'd1,
      S_SHIFT = 2'd2,
      S_DONE  = 2'd3
   } state_t;

   state_t           r_state;
   state_t           w_state_nxt;
   logic             w_accept;

   logic [WIDTH-1:0] r_q;
   logic [CW-1:0]    r_cnt;
   logic [1:0]       r_mode;
   logic             r_dir;
   logic [WIDTH-1:0] r_pdata;

   logic [WIDTH-1:0] w_q_shifted;

   // ------------------------------------------------------------------
   // FSM state register
   // ------------------------------------------------------------------
   always_ff @(posedge clk) begin
      if (rst) r_state <= S_IDLE;
      else     r_state <= w_state_nxt;
   end

   // ------------------------------------------------------------------
   // FSM next-state and control outputs
   // ------------------------------------------------------------------
   always_comb begin
      w_state_nxt = r_state;
      w_accept    = 1'b0;
      cmd_ready   = 1'b0;
      busy        = 1'b1;
      shift_en    = 1'b0;
      done        = 1'b0;
      case (r_state)
         S_IDLE: begin
            cmd_ready = 1'b1;
            busy      = 1'b0;
            if (cmd_valid) begin
               w_accept = 1'b1;
               if (cmd_mode == M_SISO)
                  // SISO needs no load; a zero count completes immediately.
                  w_state_nxt = (cmd_nshift != '0) ? S_SHIFT : S_DONE;
               else
                  w_state_nxt = S_LOAD;
            end
         end
         S_LOAD: begin
            w_state_nxt = (r_mode == M_PIPO) ? S_DONE : S_SHIFT;
         end
         S_SHIFT: begin
            shift_en = 1'b1;
            // The edge that consumes the last count also leaves SHIFT.
            if (r_cnt <= CW'(1))
               w_state_nxt = S_DONE;
         end
         S_DONE: begin
            done        = 1'b1;
            w_state_nxt = S_IDLE;
         end
         default: w_state_nxt = S_IDLE;
      endcase
   end

   // ------------------------------------------------------------------
   // Datapath: command latch, shift counter, register
   // ------------------------------------------------------------------
   assign w_q_shifted = r_dir ? {r_q[WIDTH-2:0], serial_in}
                              : {serial_in, r_q[WIDTH-1:1]};

   always_ff @(posedge clk) begin
      if (rst) begin
         r_q     <= '0;
         r_cnt   <= '0;
         r_mode  <= M_SISO;
         r_dir   <= 1'b0;
         r_pdata <= '0;
      end else begin
         case (r_state)
            S_IDLE: begin
               // Every command field is frozen here; later bus changes
               // cannot disturb a running operation.
               if (w_accept) begin
                  r_mode  <= cmd_mode;
                  r_dir   <= cmd_dir;
                  r_pdata <= cmd_pdata;
                  r_cnt   <= CW'(cmd_nshift);
               end
            end
            S_LOAD: begin
               r_q   <= (r_mode == M_SIPO) ? '0 : r_pdata;
               r_cnt <= CW'(WIDTH);
            end
            S_SHIFT: begin
               // Counts above WIDTH simply keep shifting: old data wraps
               // out of serial_out and serial_in refills the register.
               r_q   <= w_q_shifted;
               r_cnt <= r_cnt - CW'(1);
            end
            S_DONE: begin
               r_cnt <= '0;
            end
            default: r_cnt <= '0;
         endcase
      end
   end

   // The outgoing bit follows the direction of the last accepted command.
   assign serial_out = r_dir ? r_q[WIDTH-1] : r_q[0];
   assign q          = r_q;
   assign q_bar      = ~r_q;

endmodule

// File: tb/tb_shift_reg_seq_ctrl.sv
// ---------------------------------------------------------------------------
// tb_shift_reg_seq_ctrl
//   Directed bench for shift_reg_seq_ctrl (WIDTH=4, CNT_W=3). Each step
//   pushes its expected shift-cycle observations and completion results to
//   scoreboard queues; a monitor pops and compares them as the DUT produces
//   shift_en and done cycles.
// ---------------------------------------------------------------------------
module tb_shift_reg_seq_ctrl;
   localparam int W  = 4;
   localparam int CN = 3;

   logic          clk = 1'b0;
   logic          rst = 1'b1;
   logic          cmd_valid = 1'b0;
   logic          cmd_ready;
   logic [1:0]    cmd_mode = 2'b00;
   logic          cmd_dir = 1'b0;
   logic [W-1:0]  cmd_pdata = '0;
   logic [CN-1:0] cmd_nshift = '0;
   logic          serial_in = 1'b0;
   logic          serial_out, shift_en, busy, done;
   logic [W-1:0]  q, q_bar;

   always #5 clk = ~clk;

   shift_reg_seq_ctrl #(.WIDTH(W), .CNT_W(CN)) dut (
      .clk(clk), .rst(rst),
      .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
      .cmd_mode(cmd_mode), .cmd_dir(cmd_dir),
      .cmd_pdata(cmd_pdata), .cmd_nshift(cmd_nshift),
      .serial_in(serial_in), .serial_out(serial_out),
      .shift_en(shift_en), .busy(busy), .done(done),
      .q(q), .q_bar(q_bar)
   );

   typedef struct { logic so; logic [W-1:0] qb; } sh_exp_t;
   typedef struct { logic [W-1:0] q; int lat; } dn_exp_t;

   sh_exp_t sb_sh[$];
   dn_exp_t sb_dn[$];

   int tests = 0, fails = 0;
   int cyc = 0;
   int acc_cyc = 0, n_acc = 0, done_cnt = 0, done_cyc = 0;
   int ndone = 0;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      tests++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic push_sh(input logic so, input logic [W-1:0] qb);
      sh_exp_t e;
      e.so = so; e.qb = qb;
      sb_sh.push_back(e);
   endtask

   task automatic push_dn(input logic [W-1:0] qe, input int lat);
      dn_exp_t e;
      e.q = qe; e.lat = lat;
      sb_dn.push_back(e);
   endtask

   // Monitor: samples mid-cycle. acc_cyc labels the first cycle after an
   // acceptance edge (c1), so a done at c(n) shows latency n-1.
   initial begin
      logic    acc_pend;
      sh_exp_t es;
      dn_exp_t ed;
      logic [W-1:0] nq;
      acc_pend = 1'b0;
      forever begin
         @(negedge clk);
         if (acc_pend) begin
            acc_cyc = cyc;
            n_acc++;
         end
         acc_pend = cmd_valid && cmd_ready && !rst;
         if (!rst) begin
            if (shift_en) begin
               chk("shift_expected", 32'(sb_sh.size() > 0), 32'd1);
               if (sb_sh.size() > 0) begin
                  es = sb_sh.pop_front();
                  chk("shift_q", 32'(q), 32'(es.qb));
                  chk("serial_out", 32'(serial_out), 32'(es.so));
               end
            end
            if (done) begin
               done_cnt++;
               done_cyc = cyc;
               chk("done_expected", 32'(sb_dn.size() > 0), 32'd1);
               if (sb_dn.size() > 0) begin
                  ed = sb_dn.pop_front();
                  nq = ~ed.q;
                  chk("done_q", 32'(q), 32'(ed.q));
                  chk("done_qbar", 32'(q_bar), 32'(nq));
                  chk("done_latency", 32'(cyc - acc_cyc), 32'(ed.lat));
               end
            end
         end
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Present a command, wait for ready, and drop valid after the accept edge.
   task automatic issue(input logic [1:0] m, input logic d,
                        input logic [W-1:0] p, input logic [CN-1:0] n);
      int k;
      cmd_mode = m; cmd_dir = d; cmd_pdata = p; cmd_nshift = n;
      cmd_valid = 1'b1;
      k = 0;
      while (!cmd_ready && k < 50) begin
         tick();
         k++;
      end
      if (!cmd_ready) chk("issue_timeout", 32'(cmd_ready), 32'd1);
      tick();
      cmd_valid = 1'b0;
   endtask

   task automatic wait_done(input int target);
      int k;
      k = 0;
      while (done_cnt < target && k < 100) begin
         tick();
         k++;
      end
      if (done_cnt < target) chk("done_timeout", 32'(done_cnt), 32'(target));
   endtask

   initial begin
      logic sbits[4];
      int   base;
      int   k;

      // ---------------- power-on reset ----------------
      tick(); tick();
      chk("rst_q", 32'(q), 32'h0);
      chk("rst_qbar", 32'(q_bar), 32'hF);
      chk("rst_busy", 32'(busy), 32'd0);
      chk("rst_ready", 32'(cmd_ready), 32'd1);
      chk("rst_done", 32'(done), 32'd0);
      chk("rst_shift_en", 32'(shift_en), 32'd0);
      rst = 1'b0;
      tick();

      // ---------------- PISO right, pdata 1011 ----------------
      serial_in = 1'b0;
      push_sh(1'b1, 4'b1011); push_sh(1'b1, 4'b0101);
      push_sh(1'b0, 4'b0010); push_sh(1'b1, 4'b0001);
      push_dn(4'b0000, 5);
      issue(2'b01, 1'b0, 4'b1011, '0);
      ndone++;
      wait_done(ndone);

      // ---------------- SIPO right, serial_in 1,0,1,1 ----------------
      sbits = '{1'b1, 1'b0, 1'b1, 1'b1};
      push_sh(1'b0, 4'b0000); push_sh(1'b0, 4'b1000);
      push_sh(1'b0, 4'b0100); push_sh(1'b0, 4'b1010);
      push_dn(4'b1101, 5);
      issue(2'b10, 1'b0, 4'b0000, '0);
      tick();
      for (int i = 0; i < 4; i++) begin
         serial_in = sbits[i];
         tick();
      end
      ndone++;
      wait_done(ndone);

      // ---------------- PIPO 0110, then back-to-back SISO left n=2 ----------------
      serial_in = 1'b1;
      push_dn(4'b0110, 1);
      push_sh(1'b0, 4'b0110); push_sh(1'b1, 4'b1101);
      push_dn(4'b1011, 2);
      issue(2'b11, 1'b0, 4'b0110, '0);
      issue(2'b00, 1'b1, 4'b0000, 3'd2);
      ndone += 2;
      wait_done(ndone);

      // ---------------- SISO n=0: immediate done, q held ----------------
      push_dn(4'b1011, 0);
      issue(2'b00, 1'b0, 4'b0000, 3'd0);
      ndone++;
      wait_done(ndone);
      tick();
      chk("siso0_q_held", 32'(q), 32'hB);

      // ---------------- SISO right n=6 > WIDTH, serial_in=1 ----------------
      serial_in = 1'b1;
      push_sh(1'b1, 4'b1011); push_sh(1'b1, 4'b1101); push_sh(1'b0, 4'b1110);
      push_sh(1'b1, 4'b1111); push_sh(1'b1, 4'b1111); push_sh(1'b1, 4'b1111);
      push_dn(4'b1111, 6);
      issue(2'b00, 1'b0, 4'b0000, 3'd6);
      ndone++;
      wait_done(ndone);

      // ---------------- busy rejection: PIPO held valid across a PISO left ----------------
      serial_in = 1'b0;
      push_sh(1'b1, 4'b1001); push_sh(1'b0, 4'b0010);
      push_sh(1'b0, 4'b0100); push_sh(1'b1, 4'b1000);
      push_dn(4'b0000, 5);
      push_dn(4'b0101, 1);
      base = n_acc;
      issue(2'b01, 1'b1, 4'b1001, '0);
      cmd_mode = 2'b11; cmd_dir = 1'b0; cmd_pdata = 4'b0101; cmd_nshift = 3'd5;
      cmd_valid = 1'b1;
      ndone++;
      wait_done(ndone);
      chk("no_accept_while_busy", 32'(n_acc), 32'(base + 1));
      k = 0;
      while (n_acc < base + 2 && k < 20) begin
         tick();
         k++;
      end
      cmd_valid = 1'b0;
      chk("held_cmd_accepted", 32'(n_acc), 32'(base + 2));
      chk("held_cmd_accept_cycle", 32'(acc_cyc), 32'(done_cyc + 2));
      ndone++;
      wait_done(ndone);

      // ---------------- reset during PISO SHIFT ----------------
      serial_in = 1'b0;
      push_sh(1'b1, 4'b1111); push_sh(1'b1, 4'b0111);
      issue(2'b01, 1'b0, 4'b1111, '0);
      tick(); tick(); tick();
      rst = 1'b1;
      tick(); tick();
      sb_sh.delete();
      sb_dn.delete();
      rst = 1'b0;
      chk("midrst_q", 32'(q), 32'h0);
      chk("midrst_qbar", 32'(q_bar), 32'hF);
      chk("midrst_busy", 32'(busy), 32'd0);
      chk("midrst_ready", 32'(cmd_ready), 32'd1);
      chk("midrst_shift_en", 32'(shift_en), 32'd0);
      for (int i = 0; i < 6; i++) tick();
      chk("midrst_no_done", 32'(done_cnt), 32'(ndone));
      chk("midrst_q_idle", 32'(q), 32'h0);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

   // Global watchdog so the run always ends.
   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

endmodule
